// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : MIPS HI/LO register pair with an iterative shift-add
//               multiplier and restoring divider (MTHI/MTLO, MULT/MULTU,
//               DIV/DIVU). Multi-cycle operations stall the pipeline via busy.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam logic [2:0] c_OP_MTHI  = 3'b001;
   localparam logic [2:0] c_OP_MTLO  = 3'b010;
   localparam logic [2:0] c_OP_MULT  = 3'b011;
   localparam logic [2:0] c_OP_MULTU = 3'b100;
   localparam logic [2:0] c_OP_DIV   = 3'b101;
   localparam logic [2:0] c_OP_DIVU  = 3'b110;

   localparam int              c_CW   = $clog2(WIDTH);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   // Shared working register: {accumulator/remainder, multiplier/dividend-quotient}
   logic [2*WIDTH-1:0] r_prod;
   // Multiplicand (MUL) or divisor (DIV) magnitude
   logic [WIDTH-1:0]   r_opd;
   // Dividend exactly as issued, returned in HI on divide by zero
   logic [WIDTH-1:0]   r_raw_a;
   logic [c_CW-1:0]    r_count;
   logic               r_is_div;
   logic               r_div_zero;
   logic               r_neg_lo;
   logic               r_neg_hi;

   logic               w_last;
   logic               w_signed_op;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_upper;
   logic [WIDTH-1:0]   w_lower;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_rem;
   logic [2*WIDTH-1:0] w_fix_prod;
   logic [WIDTH-1:0]   w_fix_quo;
   logic [WIDTH-1:0]   w_fix_rem;

   assign w_upper = r_prod[2*WIDTH-1:WIDTH];
   assign w_lower = r_prod[WIDTH-1:0];
   assign w_last  = (r_count == c_LAST);

   // Operand conditioning, per-iteration step logic and final sign correction
   always_comb begin
      w_signed_op = (op_code == c_OP_MULT) || (op_code == c_OP_DIV);
      w_abs_a     = (w_signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
      w_abs_b     = (w_signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

      w_mul_sum   = {1'b0, w_upper} + {1'b0, (w_lower[0] ? r_opd : {WIDTH{1'b0}})};

      w_div_shift = {w_upper, w_lower[WIDTH-1]};
      w_div_ge    = (w_div_shift >= {1'b0, r_opd});
      // Only used when w_div_ge, where the true difference fits in WIDTH bits
      w_div_rem   = w_div_shift[WIDTH-1:0] - r_opd;

      w_fix_prod  = r_neg_lo ? -r_prod  : r_prod;
      w_fix_quo   = r_neg_lo ? -w_lower : w_lower;
      w_fix_rem   = r_neg_hi ? -w_upper : w_upper;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush always returns to IDLE
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (op_valid) begin
                  if (op_code == c_OP_MULT || op_code == c_OP_MULTU) begin
                     w_state_nxt = S_MUL;
                  end else if (op_code == c_OP_DIV || op_code == c_OP_DIVU) begin
                     w_state_nxt = S_DIV;
                  end
               end
            end
            S_MUL:   if (w_last) w_state_nxt = S_FIX;
            S_DIV:   if (w_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath: operand capture, iteration, HI/LO write-back and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_prod     <= '0;
         r_opd      <= '0;
         r_raw_a    <= '0;
         r_count    <= '0;
         r_is_div   <= 1'b0;
         r_div_zero <= 1'b0;
         r_neg_lo   <= 1'b0;
         r_neg_hi   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_count <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_count <= '0;
                  if (op_valid) begin
                     case (op_code)
                        c_OP_MTHI: r_hi <= op_a;
                        c_OP_MTLO: r_lo <= op_a;
                        c_OP_MULT, c_OP_MULTU: begin
                           r_prod   <= {{WIDTH{1'b0}}, w_abs_b};
                           r_opd    <= w_abs_a;
                           r_is_div <= 1'b0;
                           r_neg_lo <= w_signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                           r_neg_hi <= 1'b0;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                           r_prod     <= {{WIDTH{1'b0}}, w_abs_a};
                           r_opd      <= w_abs_b;
                           r_raw_a    <= op_a;
                           r_is_div   <= 1'b1;
                           r_div_zero <= (op_b == '0);
                           r_neg_lo   <= w_signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                           r_neg_hi   <= w_signed_op && op_a[WIDTH-1];
                        end
                        default: ;
                     endcase
                  end
               end
               S_MUL: begin
                  r_prod  <= {w_mul_sum, w_lower[WIDTH-1:1]};
                  r_count <= r_count + 1'b1;
               end
               S_DIV: begin
                  r_prod  <= {(w_div_ge ? w_div_rem : w_div_shift[WIDTH-1:0]),
                              w_lower[WIDTH-2:0], w_div_ge};
                  r_count <= r_count + 1'b1;
               end
               S_FIX: begin
                  if (r_is_div) begin
                     if (r_div_zero) begin
                        r_hi <= r_raw_a;
                        r_lo <= '1;
                     end else begin
                        r_hi <= w_fix_rem;
                        r_lo <= w_fix_quo;
                     end
                  end else begin
                     r_hi <= w_fix_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_fix_prod[WIDTH-1:0];
                  end
                  r_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = r_done;
   assign hi_out = r_hi;
   assign lo_out = r_lo;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised HI/LO register pair with an integrated iterative multiply/divide engine for the MIPS datapath. It holds the architectural HI and LO registers and services MTHI/MTLO, MULT/MULTU and DIV/DIVU. Multi-cycle operations assert a busy stall toward the pipeline. It sits beside the ALU in EX; hi_out/lo_out feed the MFHI/MFLO path.

Parameters:
WIDTH, 32, operand and HI/LO register width (even, >= 4)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  op_code/op_a/op_b valid this cycle
op_code  input  3  000 NOP, 001 MTHI, 010 MTLO, 011 MULT, 100 MULTU, 101 DIV, 110 DIVU, 111 reserved
op_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
op_b  input  WIDTH  rt operand (divisor / multiplier)
flush  input  1  synchronous abort of any in-flight operation
busy  output  1  mul/div in progress; upstream must stall HI/LO users and new ops
done  output  1  one-cycle pulse: mul/div result just written to HI/LO
hi_out  output  WIDTH  current HI
lo_out  output  WIDTH  current LO

Behaviour:
- Reset (rst_n low, async): hi_out=0, lo_out=0, busy=0, done=0, state=IDLE, internal datapath cleared. Reset mid-operation discards the operation; no done.
- States: IDLE, MUL, DIV, FIX.
- IDLE, op_valid=1, flush=0:
  - MTHI: HI<=op_a at that edge; visible next cycle; busy stays 0; no done.
  - MTLO: same for LO.
  - MULT/MULTU -> MUL; DIV/DIVU -> DIV. Operands latched: signed ops store magnitudes plus result-sign flags; unsigned ops store raw values.
  - NOP/111: no effect.
- MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX: one cycle; applies sign correction, writes HI/LO, returns to IDLE.
- Latency: acceptance edge E0; busy=1 from the cycle after E0 through edge E(WIDTH+1), i.e. exactly WIDTH+1 cycles. HI/LO update at E(WIDTH+1); done=1 for the following single cycle, concurrent with the new hi_out/lo_out. During busy, hi_out/lo_out hold their pre-operation values.
- Back-to-back: a new op may be accepted in the done cycle (busy=0 then).
- op_valid while busy: ignored entirely, including MTHI/MTLO; no queueing.
- Multiply: full 2*WIDTH product; HI=upper WIDTH bits, LO=lower. MULT treats operands as two's complement; the product is negated when operand signs differ.
- Divide: LO=quotient, HI=remainder. Signed: quotient truncates toward zero and is negative iff operand signs differ; the remainder takes the dividend's sign. MIN / -1 -> LO=MIN, HI=0, no trap.
- Divide by zero (both DIV and DIVU): full latency, HI=op_a as given, LO=all ones, done pulses.
- flush=1: next edge forces IDLE, busy=0; HI/LO unchanged; no done. flush with op_valid in the same cycle: flush wins and the op is discarded (MTHI/MTLO included). flush during the FIX cycle: write suppressed.
- No combinational path from op inputs to busy/done/hi_out/lo_out; all outputs registered.

Test Plan:
1. WIDTH=32: MTHI 0xDEADBEEF, next cycle MTLO 0x12345678 -> hi_out=0xDEADBEEF one cycle after the first edge, lo_out=0x12345678 after the second; busy never 1, done never 1.
2. MULT 0xFFFFFFFD*0x00000007 -> busy 33 cycles, done pulse, HI=0xFFFFFFFF LO=0xFFFFFFEB. MULTU with the same operands -> HI=0x00000006 LO=0xFFFFFFEB.
3. DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. Back-to-back issue in the done cycle is accepted.
4. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> HI=5, LO=0xFFFFFFFF, done after 33 busy cycles.
5. Start DIVU, raise flush in busy cycle 10 -> busy=0 next cycle, no done, HI/LO keep prior values. MTHI issued during busy -> HI unchanged.
6. Assert rst_n=0 asynchronously mid-MULT -> hi_out=lo_out=0 and busy=0 immediately; after release, MTLO 0x1 -> lo_out=0x1.
